// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer.
// Holds the 2-bit FSM state encoding and the width of the re-entry counter.
package reset_sequencer_pkg;

  localparam int unsigned STATE_W     = 2;
  localparam int unsigned RST_COUNT_W = 8;

  // Code 2'b11 is deliberately unused; the FSM treats it as a fault and
  // falls back to S_HOLD.
  typedef enum logic [STATE_W-1:0] {
    S_HOLD = 2'b00,
    S_PREL = 2'b01,
    S_RUN  = 2'b10
  } state_t;

endpackage

// File: rtl/reset_sequencer_cycle_counter.sv
// cycle_counter: qualified-cycle counter used by the reset sequencer.
// Ports:
//   clk      - system clock
//   rst      - asynchronous active-high reset, clears count to 0
//   clr      - synchronous clear (priority over en)
//   en       - advance the count this cycle
//   terminal - value at which the count wraps back to 0
//   count    - current count
//   hit      - count == terminal while en is high (combinational)
module cycle_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] terminal,
  output logic [CNT_W-1:0] count,
  output logic             hit
);

  assign hit = en && (count == terminal);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      // Wrapping on the terminal value leaves the counter at 0 for the
      // next stage without needing a separate clear.
      if (hit) count <= '0;
      else     count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: staged system reset generator for the PC core.
// Peripheral reset releases after HOLD_CYCLES consecutive qualified cycles,
// CPU reset releases STAGE_CYCLES qualified cycles later. Any request or
// power-good loss re-enters the hold state one edge after it is sampled.
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-high power-on reset
//   req        - debounced reset request (active-high)
//   pwr_good   - board power-good level (active-high)
//   periph_rst - peripheral reset (registered)
//   cpu_rst    - CPU reset (registered)
//   ready      - both resets released (registered)
//   done       - one-cycle pulse on CPU reset release (registered)
//   rst_count  - resets re-entered since power-on, saturating at 255
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES  = 16,
  parameter int unsigned STAGE_CYCLES = 4,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic                   pwr_good,
  output logic                   periph_rst,
  output logic                   cpu_rst,
  output logic                   ready,
  output logic                   done,
  output logic [RST_COUNT_W-1:0] rst_count
);

  localparam logic [CNT_W-1:0] HOLD_TERM  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_TERM = CNT_W'(STAGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_TERM   = (HOLD_TERM > STAGE_TERM) ? HOLD_TERM : STAGE_TERM;

  state_t           state;
  state_t           state_next;
  logic             qual;
  logic             cnt_clr;
  logic             cnt_en;
  logic [CNT_W-1:0] terminal;
  logic [CNT_W-1:0] count;
  logic             hit;
  logic             count_inc;

  assign qual = !req && pwr_good;

  cycle_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .terminal (terminal),
    .count    (count),
    .hit      (hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_HOLD;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    terminal   = '0;
    count_inc  = 1'b0;
    case (state)
      S_HOLD: begin
        terminal = HOLD_TERM;
        if (!qual) begin
          cnt_clr = 1'b1;
        end else begin
          cnt_en = 1'b1;
          if (hit) state_next = S_PREL;
        end
      end
      S_PREL: begin
        terminal = STAGE_TERM;
        if (!qual) begin
          cnt_clr    = 1'b1;
          state_next = S_HOLD;
          count_inc  = 1'b1;
        end else begin
          cnt_en = 1'b1;
          if (hit) state_next = S_RUN;
        end
      end
      S_RUN: begin
        cnt_clr = 1'b1;
        if (!qual) begin
          state_next = S_HOLD;
          count_inc  = 1'b1;
        end
      end
      default: begin
        state_next = S_HOLD;
        cnt_clr    = 1'b1;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register while still coming straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      periph_rst <= 1'b1;
      cpu_rst    <= 1'b1;
      ready      <= 1'b0;
      done       <= 1'b0;
      rst_count  <= '0;
    end else begin
      periph_rst <= (state_next == S_HOLD);
      cpu_rst    <= (state_next != S_RUN);
      ready      <= (state_next == S_RUN);
      done       <= (state == S_PREL) && (state_next == S_RUN);
      if (count_inc && (rst_count != '1)) rst_count <= rst_count + 1'b1;
    end
  end

  a_count_range: assert property (@(posedge clk) disable iff (rst) count <= MAX_TERM);

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Consumes the debounced button-reset pulse and the board power-good level.
- Produces the staged system resets for the PC core:
  - Peripheral reset (8253/8255/8259/DMA) releases first.
  - CPU reset releases a fixed number of cycles later, so the CPU never fetches from unready peripherals.
- Sits between the debounce block and the 8088 core and bus peripherals. Its output is the single source of reset for everything downstream.

Parameters:
- HOLD_CYCLES, 16, qualified cycles both resets stay asserted after the last request or power fault (≥1).
- STAGE_CYCLES, 4, cycles between peripheral release and CPU release (≥1).
- CNT_W, 8, width of the internal cycle counter. It must hold max(HOLD_CYCLES, STAGE_CYCLES)-1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high (power-on reset).
- req  in  1  debounced reset request, active-high, any width ≥1 cycle, synchronous to clk.
- pwr_good  in  1  power-good level, active-high, synchronous to clk.
- periph_rst  out  1  peripheral reset, active-high, registered.
- cpu_rst  out  1  CPU reset, active-high, registered.
- ready  out  1  high when both resets are released (system running), registered.
- done  out  1  one-cycle pulse on the edge cpu_rst releases, registered.
- rst_count  out  8  number of resets re-entered since power-on; saturates at 255.

Behaviour:
- On rst=1, asynchronously and immediately:
  - state=S_HOLD, counter=0.
  - periph_rst=1, cpu_rst=1, ready=0, done=0, rst_count=0.
- qual = req==0 && pwr_good==1.
- States use a 2-bit encoding: S_HOLD=00, S_PREL=01, S_RUN=10. Code 11 is illegal: go to S_HOLD, counter=0, both resets asserted.
- S_HOLD (periph_rst=1, cpu_rst=1, ready=0):
  - !qual: counter cleared to 0.
  - qual and counter<HOLD_CYCLES-1: counter+1.
  - qual and counter==HOLD_CYCLES-1: go to S_PREL, counter=0, periph_rst=0 on that edge.
- S_PREL (periph_rst=0, cpu_rst=1, ready=0):
  - !qual: go to S_HOLD, counter=0, periph_rst=1 next edge, rst_count+1.
  - qual and counter<STAGE_CYCLES-1: counter+1.
  - qual and counter==STAGE_CYCLES-1: go to S_RUN, cpu_rst=0, ready=1, done=1 on that edge.
- S_RUN (periph_rst=0, cpu_rst=0, ready=1):
  - !qual: go to S_HOLD; periph_rst=1, cpu_rst=1, ready=0 on that edge; rst_count+1.
- done is high for exactly one cycle per S_PREL→S_RUN transition; otherwise 0.
- Latency from rst deassertion with qual held:
  - periph_rst falls at the HOLD_CYCLES-th rising edge.
  - cpu_rst falls at edge HOLD_CYCLES+STAGE_CYCLES.
- Resets assert one edge after req or pwr_good loss is sampled in any state.
- Both req=1 and pwr_good=0 in the same cycle count as a single reset event.
- rst_count:
  - Increments only on S_PREL/S_RUN → S_HOLD transitions.
  - Does not increment on async rst or while already in S_HOLD.
  - Holds at 255.
- All outputs come straight from flops: no combinational path from any input to any output.

Decomposition:
- Shared include reset_seq_defs.vh holds:
  - State encodings S_HOLD/S_PREL/S_RUN and the 2-bit state width.
  - The rst_count width (8).
- One sub-module, cycle_counter (CNT_W parameter):
  - Inputs: clr, en, terminal value.
  - Outputs: count, hit (count==terminal && en).
  - Async reset to 0.
- The FSM and output registers stay in reset_sequencer.

Test Plan:
- Power-on: rst=1 for 3 cycles, then 0; req=0, pwr_good=1.
  - Response: outputs at reset values during rst.
  - periph_rst falls at edge 16, cpu_rst and ready change at edge 20, done high for exactly 1 cycle, rst_count=0.
- Button reset from S_RUN: 1-cycle req pulse.
  - Response: periph_rst, cpu_rst =1 and ready=0 on the next edge; rst_count=1.
  - Release sequence repeats with 16/4-cycle spacing measured from req falling.
- Abort in S_PREL: req pulse 2 cycles after periph_rst release.
  - Response: periph_rst reasserts next edge, cpu_rst never falls, done never pulses, rst_count+1.
  - Full 16+4 release follows.
- Power fault: pwr_good=0 for 10 cycles while in S_HOLD at counter=12.
  - Response: counter restarts; periph_rst falls 16 edges after pwr_good returns; rst_count unchanged.
- Async reset mid-S_PREL: rst pulse between clock edges.
  - Response: outputs return to reset values without waiting for clk; rst_count=0.
- Saturation: 260 req pulses, each after reaching S_RUN.
  - Response: rst_count reaches 255 and holds.
